// File: rtl/rand_word_fifo_if.sv
// Bundle of the nibble-source and word-consumer signals of rand_word_fifo.
// master: the FIFO block side; slave: the PRNG/consumer side.
interface rand_word_fifo_if #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

   logic [3:0]        nib_in;
   logic              nib_done;
   logic              prng_ena;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic              word_ready;
   logic [FILL_W-1:0] fill;
   logic              ovf;
   logic              health_err;

   modport master (
      input  nib_in, nib_done, word_ready,
      output prng_ena, word_out, word_valid, fill, ovf, health_err
   );

   modport slave (
      output nib_in, nib_done, word_ready,
      input  prng_ena, word_out, word_valid, fill, ovf, health_err
   );
endinterface

// File: rtl/rand_word_fifo.sv
// Assembles PRNG nibbles into words and buffers them in a show-ahead FIFO.
// Optional repetition health check enabled by defining RAND_HEALTH_CHECK_EN.
module rand_word_fifo #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             en,
   rand_word_fifo_if.master bus
);
   localparam int unsigned NIBS   = WORD_W / 4;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FILL_W = PTR_W + 1;
   localparam int unsigned IDX_W  = $clog2(NIBS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBS - 1);
   localparam logic [FILL_W-1:0] FULL     = FILL_W'(DEPTH);

   logic              r_done_q;
   logic [IDX_W-1:0]  r_nib_idx;
   logic [WORD_W-1:0] r_partial;
   logic              r_pend_vld;
   logic [WORD_W-1:0] r_pend_word;
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [FILL_W-1:0] r_fill;
   logic              r_ovf;

   logic              w_cap;
   logic              w_last;
   logic [WORD_W-1:0] w_word;
   logic              w_block;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [FILL_W-1:0] w_fill_nxt;

   // Only the rising edge of nib_done delivers a nibble.
   assign w_cap  = en & bus.nib_done & ~r_done_q;
   assign w_last = w_cap & (r_nib_idx == LAST_IDX);

   always_comb begin
      w_word = r_partial;
      w_word[{r_nib_idx, 2'b00} +: 4] = bus.nib_in;
   end

   assign w_full = (r_fill == FULL);
   assign w_pop  = (r_fill != '0) & bus.word_ready;
   assign w_push = r_pend_vld & (~w_full | w_pop);
   assign w_drop = r_pend_vld & w_full & ~w_pop;

   always_comb begin
      w_fill_nxt = r_fill;
      if (w_push && !w_pop) begin
         w_fill_nxt = r_fill + FILL_W'(1);
      end else if (w_pop && !w_push) begin
         w_fill_nxt = r_fill - FILL_W'(1);
      end
   end

`ifdef RAND_HEALTH_CHECK_EN
   logic [WORD_W-1:0] r_prev_word;
   logic              r_have_prev;
   logic [1:0]        r_rep_cnt;
   logic              r_health_err;
   logic              w_same;
   logic [1:0]        w_rep_nxt;

   assign w_same = r_have_prev & (w_word == r_prev_word);

   always_comb begin
      w_rep_nxt = 2'd0;
      if (w_same) begin
         w_rep_nxt = (r_rep_cnt == 2'd2) ? 2'd2 : r_rep_cnt + 2'd1;
      end
   end

   // Third and later identical words in a row are never pushed.
   assign w_block = (w_rep_nxt == 2'd2);

   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_prev_word  <= '0;
         r_have_prev  <= 1'b0;
         r_rep_cnt    <= 2'd0;
         r_health_err <= 1'b0;
      end else if (w_last) begin
         r_prev_word <= w_word;
         r_have_prev <= 1'b1;
         r_rep_cnt   <= w_rep_nxt;
         if (w_block) begin
            r_health_err <= 1'b1;
         end
      end
   end

   assign bus.health_err = r_health_err;
`else
   assign w_block        = 1'b0;
   assign bus.health_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_done_q    <= 1'b0;
         r_nib_idx   <= '0;
         r_partial   <= '0;
         r_pend_vld  <= 1'b0;
         r_pend_word <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_fill      <= '0;
         r_ovf       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_done_q   <= bus.nib_done;
         r_pend_vld <= w_last & ~w_block;
         if (w_last) begin
            r_pend_word <= w_word;
         end
         if (w_cap) begin
            if (w_last) begin
               r_nib_idx <= '0;
               r_partial <= '0;
            end else begin
               r_nib_idx <= r_nib_idx + IDX_W'(1);
               r_partial <= w_word;
            end
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= r_pend_word;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_fill <= w_fill_nxt;
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign bus.prng_ena   = res_n & en & ~w_full;
   assign bus.word_out   = r_mem[r_rd_ptr];
   assign bus.word_valid = (r_fill != '0);
   assign bus.fill       = r_fill;
   assign bus.ovf        = r_ovf;
endmodule

// File: doc/rand_word_fifo.md
RAND_WORD_FIFO -- requirements
Module: rand_word_fifo

Interface
REQ-001 SHALL have parameter WORD_W, default 16: output word width; multiple of 4, range 8..32.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO depth in words; power of two, range 2..16.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port res_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have port en  input  1: block enable; low suspends nibble requests and capture.
REQ-006 SHALL have port nib_in  input  4: nibble from the upstream PRNG dout.
REQ-007 SHALL have port nib_done  input  1: upstream done flag; nibble valid on its rising edge.
REQ-008 SHALL have port prng_ena  output  1: enable to the upstream PRNG.
REQ-009 SHALL have port word_out  output  WORD_W: FIFO head word (show-ahead).
REQ-010 SHALL have port word_valid  output  1: high when the FIFO holds at least one word.
REQ-011 SHALL have port word_ready  input  1: consumer accepts word_out when word_valid is also high.
REQ-012 SHALL have port fill  output  $clog2(DEPTH)+1: current FIFO occupancy.
REQ-013 SHALL have port ovf  output  1: sticky flag; a completed word was dropped.
REQ-014 SHALL have port health_err  output  1: sticky repetition-test failure flag.

Function
REQ-015 SHALL register nib_done as done_q and capture nib_in only when en=1, nib_done=1 and done_q=0; a held-high done is one nibble.
REQ-016 SHALL place captured nibble k (k=0..WORD_W/4-1) at bits [4k+3:4k]; nibble 0 is the LSB nibble.
REQ-017 SHALL complete a word on the cycle the last nibble is captured, then reset the nibble index to 0.
REQ-018 SHALL write a completed word into the FIFO on the following edge when fill<DEPTH or a pop happens on that same edge.
REQ-019 SHALL drop a completed word when fill=DEPTH and no pop happens; it SHALL set ovf, and fill SHALL stay at DEPTH.
REQ-020 SHALL pop when word_valid=1 and word_ready=1; word_ready with an empty FIFO SHALL have no effect.
REQ-021 SHALL handle push and pop on the same edge by leaving fill unchanged and advancing both pointers; this holds at fill=DEPTH.
REQ-022 SHALL drive prng_ena = en AND (fill < DEPTH), combinationally from registered fill.
REQ-023 SHALL keep a partial word and its nibble index when en drops; assembly resumes when en returns.
REQ-024 SHALL use wrap-around pointers of $clog2(DEPTH) bits; word_out SHALL equal mem[rd_ptr].
REQ-025 SHALL have a latency of 2 clk edges from the capture edge of the last nibble to word_valid=1, starting from an empty FIFO.

Reset
REQ-026 SHALL, when res_n=0 on an edge, clear pointers, fill, nibble index, partial word, done_q, ovf and health_err; reset SHALL take priority over all events.
REQ-027 SHALL hold all outputs at 0 while res_n=0: word_valid, fill, ovf and health_err at 0; prng_ena at 0; word_out at 0, with FIFO contents cleared.
REQ-028 SHALL, on reset mid-word, discard the partial word; the first nibble after reset SHALL be nibble 0.

Configuration
REQ-029 SHALL, with macro RAND_HEALTH_CHECK_EN defined, compare each completed word with the previous completed word and count consecutive equals.
REQ-030 SHALL, with RAND_HEALTH_CHECK_EN defined, set health_err when a word equals the previous one twice in a row (three identical words), and SHALL NOT push that third word or any later identical word.
REQ-031 SHALL, with RAND_HEALTH_CHECK_EN defined, clear the repeat count on reset and on any differing word.
REQ-032 SHALL, without RAND_HEALTH_CHECK_EN, tie health_err to 0 and push every completed word.

Verification
REQ-033 SHALL cover: WORD_W=16, nibbles 1,2,3,4 on done pulses -> word_out=16'h4321, word_valid 2 edges after the 4th capture, fill=1.
REQ-034 SHALL cover: nib_done held high 5 cycles with nib_in=A -> exactly one nibble captured, nibble index=1.
REQ-035 SHALL cover: DEPTH=4 filled with word_ready=0 -> prng_ena=0 at fill=4; a 5th word (stray done) is dropped, ovf=1, FIFO contents unchanged.
REQ-036 SHALL cover: fill=4 with push and pop on the same edge -> fill stays 4, head advances, ovf stays 0.
REQ-037 SHALL cover: res_n=0 after 2 nibbles, then nibbles 5,6,7,8 -> word_out=16'h8765, flags 0.
REQ-038 SHALL cover, with RAND_HEALTH_CHECK_EN: three words 16'hBEEF -> health_err=1 after the third, fill=2.
